midi_message_encoder: RTL

Converts parallel note/controller events into a serial MIDI byte stream for the UART transmit path, the outbound counterpart of the MIDI decode datapath/control pair. It accepts one event at a time over a valid/ready handshake. It emits the status byte and then 1–2 data bytes over a byte-wide valid/ready interface that feeds the UART `DataIn` side. The optional running-status mode drops repeated status bytes and forces a periodic status refresh.

---
 rtl/midi_message_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/midi_message_encoder.sv
// midi_message_encoder: turns one parallel note/controller event into a MIDI status + data byte stream.
// Latency: first byte is valid the cycle after capture, then one byte per cycle while DataOutReady is high.
// Backpressure: DataOut/DataOutValid hold while DataOutReady is low; EventReady is high only when idle.
module midi_message_encoder #(
   parameter bit          RunningStatus = 1'b1,
   parameter int unsigned RefreshCycles = 30000000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       EventValid,
   output logic       EventReady,
   input  logic [1:0] EventType,
   input  logic [3:0] Channel,
   input  logic [6:0] Data1,
   input  logic [6:0] Data2,
   output logic [7:0] DataOut,
   output logic       DataOutValid,
   input  logic       DataOutReady
);

   localparam int unsigned CntWidth = $clog2(RefreshCycles + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(RefreshCycles);

   typedef enum logic [1:0] {IDLE = 2'd0, STATUS = 2'd1, DATA1 = 2'd2, DATA2 = 2'd3} state_t;

   // Program change is the only two-byte message; control change maps to 0xBn, not 0xAn.
   function automatic logic [7:0] status_byte(input logic [1:0] ev_type, input logic [3:0] chan);
      logic [2:0] code;
      case (ev_type)
         2'b00:   code = 3'b000;
         2'b01:   code = 3'b001;
         2'b10:   code = 3'b011;
         default: code = 3'b100;
      endcase
      return {1'b1, code, chan};
   endfunction

   state_t state;
   state_t state_next;

   logic [1:0] ev_type;
   logic [3:0] ev_chan;
   logic [6:0] ev_data1;
   logic [6:0] ev_data2;

   logic [7:0]          last_status;
   logic                status_valid;
   logic [CntWidth-1:0] stale_cnt;

   logic       capture;
   logic       byte_done;
   logic [7:0] new_status;
   logic       skip_status;

   logic [1:0] nxt_type;
   logic [3:0] nxt_chan;
   logic [6:0] nxt_data1;
   logic [6:0] nxt_data2;
   logic [7:0] nxt_out;
   logic       nxt_valid;
   logic       nxt_ready;

   assign capture    = EventValid & EventReady;
   assign byte_done  = DataOutValid & DataOutReady;
   assign new_status = status_byte(EventType, Channel);
   // Counter is sampled at the capture edge: a saturated counter means the status must be refreshed.
   assign skip_status = RunningStatus && status_valid && (last_status == new_status) &&
                        (stale_cnt < CntMax);

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state: advance one byte per handshake; program change has no second data byte
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (capture)   state_next = skip_status ? DATA1 : STATUS;
         STATUS:  if (byte_done) state_next = DATA1;
         DATA1:   if (byte_done) state_next = (ev_type == 2'b11) ? IDLE : DATA2;
         DATA2:   if (byte_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode for the upcoming state, so the byte port comes straight from flops
   always_comb begin
      nxt_type  = capture ? EventType : ev_type;
      nxt_chan  = capture ? Channel   : ev_chan;
      nxt_data1 = capture ? Data1     : ev_data1;
      nxt_data2 = capture ? Data2     : ev_data2;
      nxt_out   = 8'h00;
      nxt_valid = 1'b0;
      nxt_ready = 1'b0;
      case (state_next)
         IDLE:    nxt_ready = 1'b1;
         STATUS:  begin nxt_out = status_byte(nxt_type, nxt_chan); nxt_valid = 1'b1; end
         DATA1:   begin nxt_out = {1'b0, nxt_data1};              nxt_valid = 1'b1; end
         DATA2:   begin nxt_out = {1'b0, nxt_data2};              nxt_valid = 1'b1; end
         default: nxt_ready = 1'b0;
      endcase
   end

   // Registered outputs and captured event fields
   always_ff @(posedge Clock) begin
      if (Reset) begin
         DataOut      <= 8'h00;
         DataOutValid <= 1'b0;
         EventReady   <= 1'b1;
         ev_type      <= 2'b00;
         ev_chan      <= 4'h0;
         ev_data1     <= 7'h00;
         ev_data2     <= 7'h00;
      end else begin
         DataOut      <= nxt_out;
         DataOutValid <= nxt_valid;
         EventReady   <= nxt_ready;
         ev_type      <= nxt_type;
         ev_chan      <= nxt_chan;
         ev_data1     <= nxt_data1;
         ev_data2     <= nxt_data2;
      end
   end

   // Running-status memory: restart the stale timer whenever a status byte actually leaves
   always_ff @(posedge Clock) begin
      if (Reset) begin
         last_status  <= 8'h00;
         status_valid <= 1'b0;
         stale_cnt    <= '0;
      end else if (state == STATUS && byte_done) begin
         last_status  <= DataOut;
         status_valid <= 1'b1;
         stale_cnt    <= '0;
      end else if (status_valid && stale_cnt != CntMax) begin
         stale_cnt    <= stale_cnt + CntWidth'(1);
      end
   end

endmodule
